memoryout_tx: RTL and testbench

- Memory-to-UART read-out path; counterpart of the write-side data selector that loads memory from UART receive bytes or multiplier results.
- On a start pulse, decodes the same 4-bit operation code and reads one or more 16-bit words from data memory.
- Splits each word into bytes and streams them to the UART transmitter over a valid/ready handshake.
- Sits between the data memory read port and the UART TX module, under control of the top-level operation FSM.

---
 rtl/memoryout_tx_if.sv | 33 +++
 rtl/memoryout_tx.sv | 188 ++++++++++++++++++
 tb/tb_memoryout_tx.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memoryout_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : memoryout_tx_if                                                 |
// | Brief    : Request, memory-read and UART-TX bundle of the read-out path.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface memoryout_tx_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [3:0]        controll;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   dump_len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_dout;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, controll, base_addr, dump_len, mem_dout, tx_ready,
        output mem_rd_en, mem_addr, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, controll, base_addr, dump_len, mem_dout, tx_ready,
        input  mem_rd_en, mem_addr, tx_data, tx_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/memoryout_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : memoryout_tx                                                    |
// | Brief    : Reads 16-bit words from data memory and streams their bytes to  |
// |            the UART TX. Define MEMOUT_CRLF_EN to append 0x0D 0x0A.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module memoryout_tx #(
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input wire             clk,
    input wire             rst_n,
    memoryout_tx_if.master bus
);
    typedef logic [3:0] state_t;

    localparam state_t c_st_idle    = 4'd0;
    localparam state_t c_st_rd      = 4'd1;
    localparam state_t c_st_wait    = 4'd2;
    localparam state_t c_st_send_hi = 4'd3;
    localparam state_t c_st_send_lo = 4'd4;
    localparam state_t c_st_next    = 4'd5;
    localparam state_t c_st_done    = 4'd6;
`ifdef MEMOUT_CRLF_EN
    localparam state_t c_st_send_cr = 4'd7;
    localparam state_t c_st_send_lf = 4'd8;
`endif

    localparam logic [3:0] c_op_showmove = 4'b0100;
    localparam logic [3:0] c_op_showadd  = 4'b0110;
    localparam logic [3:0] c_op_showsub  = 4'b1000;
    localparam logic [3:0] c_op_showmul  = 4'b1010;
    localparam logic [3:0] c_op_show     = 4'b1011;

    localparam logic [ADDR_W:0]   c_len_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [1:0]        c_wait_init = 2'(RD_LAT - 1);
    localparam logic [1:0]        c_wait_one  = 2'd1;

    state_t            r_state;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_lo_byte;
    logic [ADDR_W:0]   r_remain;
    logic              r_lo_only;
    logic [1:0]        r_wait;

    logic              w_accept;
    logic              w_lo_only;
    logic [ADDR_W:0]   w_len;

    // Operation decode; only the show* codes produce UART traffic.
    always_comb begin
        w_accept  = 1'b1;
        w_lo_only = 1'b0;
        w_len     = c_len_one;
        case (bus.controll)
            c_op_showmove, c_op_showadd, c_op_showsub: w_lo_only = 1'b1;
            c_op_showmul:                              w_lo_only = 1'b0;
            c_op_show:                                 w_len     = bus.dump_len;
            default:                                   w_accept  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lo_byte  <= '0;
            r_remain   <= '0;
            r_lo_only  <= 1'b0;
            r_wait     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.start && w_accept) begin
                        r_addr    <= bus.base_addr;
                        r_lo_only <= w_lo_only;
                        r_remain  <= w_len;
                        r_busy    <= 1'b1;
                        if (w_len == '0) begin
                            r_state <= c_st_next;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_state <= c_st_rd;
                        end
                    end
                end
                c_st_rd: begin
                    r_rd_en <= 1'b0;
                    r_wait  <= c_wait_init;
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (r_wait == '0) begin
                        // Only the low byte has to outlive this cycle; the high byte goes straight out.
                        r_lo_byte  <= bus.mem_dout[7:0];
                        r_tx_valid <= 1'b1;
                        if (r_lo_only) begin
                            r_tx_data <= bus.mem_dout[7:0];
                            r_state   <= c_st_send_lo;
                        end else begin
                            r_tx_data <= bus.mem_dout[15:8];
                            r_state   <= c_st_send_hi;
                        end
                    end else begin
                        r_wait <= r_wait - c_wait_one;
                    end
                end
                c_st_send_hi: begin
                    if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= r_lo_byte;
                        r_state    <= c_st_send_lo;
                    end
                end
                c_st_send_lo: begin
                    // Entered with valid low after a high byte: one idle cycle before re-presenting.
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                    end else if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= c_st_next;
                    end
                end
                c_st_next: begin
                    r_addr <= r_addr + c_addr_one;
                    if (r_remain > c_len_one) begin
                        r_remain <= r_remain - c_len_one;
                        r_rd_en  <= 1'b1;
                        r_state  <= c_st_rd;
                    end else begin
                        r_remain <= '0;
`ifdef MEMOUT_CRLF_EN
                        r_tx_data  <= 8'h0D;
                        r_tx_valid <= 1'b1;
                        r_state    <= c_st_send_cr;
`else
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_st_done;
`endif
                    end
                end
`ifdef MEMOUT_CRLF_EN
                c_st_send_cr: begin
                    if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'h0A;
                        r_state    <= c_st_send_lf;
                    end
                end
                c_st_send_lf: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                    end else if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= c_st_done;
                    end
                end
`endif
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.mem_rd_en = r_rd_en;
    assign bus.mem_addr  = r_addr;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_memoryout_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_memoryout_tx                                                 |
// | Brief    : Randomized bench for memoryout_tx against a byte-stream model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_memoryout_tx;
    localparam int ADDR_W = 4;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [3:0] OP_LOAD     = 4'b0001;
    localparam logic [3:0] OP_SHOWMOVE = 4'b0100;
    localparam logic [3:0] OP_SHOWADD  = 4'b0110;
    localparam logic [3:0] OP_SHOWSUB  = 4'b1000;
    localparam logic [3:0] OP_SHOWMUL  = 4'b1010;
    localparam logic [3:0] OP_SHOW     = 4'b1011;
`ifdef MEMOUT_CRLF_EN
    localparam int DUMP0_DONE_CYC = 5;
`else
    localparam int DUMP0_DONE_CYC = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    memoryout_tx_if #(.ADDR_W(ADDR_W)) bus ();
    memoryout_tx #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory with RD_LAT-cycle read latency; garbage when no read is in flight.
    logic [15:0] mem  [DEPTH];
    logic [15:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= bus.mem_rd_en ? mem[bus.mem_addr] : 16'hDEAD;
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_dout = pipe[RD_LAT-1];

    int errors = 0;
    int checks = 0;

    logic [7:0] got_bytes[$];
    logic [7:0] exp_bytes[$];
    int         got_addrs[$];
    int         exp_addrs[$];
    bit         exp_active;
    string      got_b_s, exp_b_s, got_a_s, exp_a_s;
    int         done_cnt, done_cyc, first_valid_cyc;
    int         hold_bad, gap_bad, busy_bad, stall_seen;

    task automatic fill_mem();
        foreach (mem[i]) mem[i] = 16'($urandom);
    endtask

    // Expected byte stream and read addresses straight from the operation rules.
    task automatic build_model(input logic [3:0] op, input int base, input int len);
        int  nwords;
        bit  lo_only;
        int  a;
        exp_bytes.delete();
        exp_addrs.delete();
        exp_active = 1'b1;
        lo_only    = 1'b0;
        nwords     = 1;
        case (op)
            OP_SHOWMOVE, OP_SHOWADD, OP_SHOWSUB: lo_only = 1'b1;
            OP_SHOWMUL:                          lo_only = 1'b0;
            OP_SHOW:                             nwords  = len;
            default: begin exp_active = 1'b0; nwords = 0; end
        endcase
        for (int i = 0; i < nwords; i++) begin
            a = (base + i) % DEPTH;
            exp_addrs.push_back(a);
            if (!lo_only) exp_bytes.push_back(mem[a][15:8]);
            exp_bytes.push_back(mem[a][7:0]);
        end
`ifdef MEMOUT_CRLF_EN
        if (exp_active) begin
            exp_bytes.push_back(8'h0D);
            exp_bytes.push_back(8'h0A);
        end
`endif
    endtask

    // Drives one request and records what the DUT does; cycle 0 is the start cycle.
    task automatic run_op(input logic [3:0] op, input int base, input int len,
                          input int ready_pct, input int stall, input bit restart);
        logic [7:0] prev_data;
        bit         prev_valid, prev_acc, acc;
        int         stall_left, cyc;
        int         budget = 600;
        got_bytes.delete();
        got_addrs.delete();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        hold_bad = 0; gap_bad = 0; busy_bad = 0; stall_seen = 0;
        stall_left = stall; prev_valid = 1'b0; prev_acc = 1'b0; prev_data = '0;
        build_model(op, base, len);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.controll  = op;
        bus.base_addr = ADDR_W'(base);
        bus.dump_len  = (ADDR_W+1)'(len);
        bus.tx_ready  = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            acc = bus.tx_valid && bus.tx_ready;
            if (bus.mem_rd_en) got_addrs.push_back(int'(bus.mem_addr));
            if (bus.tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (acc) got_bytes.push_back(bus.tx_data);
            if (prev_valid && !prev_acc && (!bus.tx_valid || bus.tx_data !== prev_data)) hold_bad++;
            if (prev_acc && bus.tx_valid) gap_bad++;
            if (bus.tx_valid && !bus.tx_ready && stall_left > 0) begin
                stall_seen++;
                stall_left--;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (bus.busy !== 1'b0) busy_bad++;
            end else if (bus.busy !== (exp_active && cyc > 0 && done_cyc < 0)) begin
                busy_bad++;
            end
            prev_valid = bus.tx_valid;
            prev_acc   = acc;
            prev_data  = bus.tx_data;
            if (done_cyc >= 0 ? (cyc >= done_cyc + 3) : (!exp_active && cyc >= 20)) break;
            @(posedge clk); #1;
            bus.start = restart && exp_active && (cyc == 1);
            if (bus.start) begin
                bus.controll  = OP_SHOWMUL;
                bus.base_addr = ADDR_W'(base + 5);
            end
            bus.tx_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
            cyc++;
        end
        bus.start = 1'b0;
        checks++;
        if (cyc >= budget) begin
            errors++;
            $display("FAIL timeout op=%b: no done after %0d cycles, required within %0d", op, cyc, budget);
        end
        got_b_s = ""; exp_b_s = ""; got_a_s = ""; exp_a_s = "";
        foreach (got_bytes[i]) got_b_s = {got_b_s, $sformatf("%02h ", got_bytes[i])};
        foreach (exp_bytes[i]) exp_b_s = {exp_b_s, $sformatf("%02h ", exp_bytes[i])};
        foreach (got_addrs[i]) got_a_s = {got_a_s, $sformatf("%0d ", got_addrs[i])};
        foreach (exp_addrs[i]) exp_a_s = {exp_a_s, $sformatf("%0d ", exp_addrs[i])};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.controll = '0; bus.base_addr = '0; bus.dump_len = '0; bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.tx_data, bus.tx_valid, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset outputs: rd_en=%b addr=%0d data=%h valid=%b busy=%b done=%b, required all zero",
                     bus.mem_rd_en, bus.mem_addr, bus.tx_data, bus.tx_valid, bus.busy, bus.done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_showadd();
        fill_mem();
        mem[3] = 16'h00A5;
        run_op(OP_SHOWADD, 3, 0, 100, 0, 1'b0);
        checks += 4;
        if (got_b_s != exp_b_s) begin errors++; $display("FAIL showadd bytes: got [%s] required [%s]", got_b_s, exp_b_s); end
        if (done_cnt !== 1) begin errors++; $display("FAIL showadd done pulses: got %0d required 1", done_cnt); end
        if (busy_bad !== 0) begin errors++; $display("FAIL showadd busy: %0d bad cycles, required 0", busy_bad); end
        if (first_valid_cyc !== 2 + RD_LAT) begin
            errors++; $display("FAIL showadd latency: first valid at %0d required %0d", first_valid_cyc, 2 + RD_LAT);
        end
    endtask

    task automatic test_showmul();
        fill_mem();
        mem[7] = 16'h1234;
        run_op(OP_SHOWMUL, 7, 0, 60, 0, 1'b0);
        checks += 3;
        if (got_b_s != exp_b_s) begin errors++; $display("FAIL showmul bytes: got [%s] required [%s]", got_b_s, exp_b_s); end
        if (done_cnt !== 1) begin errors++; $display("FAIL showmul done pulses: got %0d required 1", done_cnt); end
        if (hold_bad + gap_bad + busy_bad !== 0) begin
            errors++; $display("FAIL showmul protocol: hold=%0d gap=%0d busy=%0d, required 0", hold_bad, gap_bad, busy_bad);
        end
    endtask

    task automatic test_show_wrap();
        fill_mem();
        mem[14] = 16'hAABB; mem[15] = 16'hCCDD; mem[0] = 16'hEEFF;
        run_op(OP_SHOW, 14, 3, 50, 0, 1'b0);
        checks += 4;
        if (got_b_s != exp_b_s) begin errors++; $display("FAIL wrap bytes: got [%s] required [%s]", got_b_s, exp_b_s); end
        if (got_a_s != exp_a_s) begin errors++; $display("FAIL wrap addrs: got [%s] required [%s]", got_a_s, exp_a_s); end
        if (done_cnt !== 1) begin errors++; $display("FAIL wrap done pulses: got %0d required 1", done_cnt); end
        if (hold_bad + gap_bad + busy_bad !== 0) begin
            errors++; $display("FAIL wrap protocol: hold=%0d gap=%0d busy=%0d, required 0", hold_bad, gap_bad, busy_bad);
        end
    endtask

    task automatic test_stall();
        fill_mem();
        mem[1] = 16'h0042;
        run_op(OP_SHOWSUB, 1, 0, 100, 10, 1'b0);
        checks += 3;
        if (stall_seen !== 10) begin errors++; $display("FAIL stall cycles: valid-while-not-ready %0d required 10", stall_seen); end
        if (hold_bad !== 0) begin errors++; $display("FAIL stall hold: %0d unstable cycles, required 0", hold_bad); end
        if (got_b_s != exp_b_s) begin errors++; $display("FAIL stall bytes: got [%s] required [%s]", got_b_s, exp_b_s); end
    endtask

    task automatic test_ignored_and_empty();
        fill_mem();
        run_op(OP_LOAD, 2, 0, 100, 0, 1'b0);
        checks += 3;
        if (got_b_s != "" || got_a_s != "") begin
            errors++; $display("FAIL load activity: bytes [%s] addrs [%s], required none", got_b_s, got_a_s);
        end
        if (done_cnt !== 0) begin errors++; $display("FAIL load done pulses: got %0d required 0", done_cnt); end
        if (busy_bad !== 0) begin errors++; $display("FAIL load busy: %0d bad cycles, required 0", busy_bad); end
        run_op(OP_SHOW, 9, 0, 100, 0, 1'b0);
        checks += 3;
        if (got_b_s != exp_b_s || got_a_s != "") begin
            errors++; $display("FAIL dump0 traffic: bytes [%s] addrs [%s], required bytes [%s] no reads", got_b_s, got_a_s, exp_b_s);
        end
        if (done_cnt !== 1) begin errors++; $display("FAIL dump0 done pulses: got %0d required 1", done_cnt); end
        if (done_cyc !== DUMP0_DONE_CYC) begin
            errors++; $display("FAIL dump0 done cycle: got %0d required %0d", done_cyc, DUMP0_DONE_CYC);
        end
    endtask

    task automatic test_full_dump();
        int base;
        fill_mem();
        base = $urandom_range(0, DEPTH - 1);
        run_op(OP_SHOW, base, DEPTH, 70, 0, 1'b1);
        checks += 3;
        if (got_b_s != exp_b_s) begin errors++; $display("FAIL full bytes: got [%s] required [%s]", got_b_s, exp_b_s); end
        if (got_a_s != exp_a_s) begin errors++; $display("FAIL full addrs: got [%s] required [%s]", got_a_s, exp_a_s); end
        if (hold_bad + gap_bad + busy_bad !== 0 || done_cnt !== 1) begin
            errors++; $display("FAIL full protocol: hold=%0d gap=%0d busy=%0d done=%0d, required 0/0/0/1",
                               hold_bad, gap_bad, busy_bad, done_cnt);
        end
    endtask

    task automatic test_reset_midway();
        int acc_cnt = 0;
        int cyc     = 0;
        int late    = 0;
        fill_mem();
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.controll  = OP_SHOW;
        bus.base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        bus.dump_len  = (ADDR_W+1)'(4);
        bus.tx_ready  = 1'b1;
        while (acc_cnt < 3 && cyc < 100) begin
            @(negedge clk);
            if (bus.tx_valid && bus.tx_ready) acc_cnt++;
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        checks++;
        if (acc_cnt < 3) begin errors++; $display("FAIL rstmid progress: accepted %0d bytes, required 3", acc_cnt); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.tx_data, bus.tx_valid, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL rstmid outputs: rd_en=%b addr=%0d data=%h valid=%b busy=%b done=%b, required all zero",
                     bus.mem_rd_en, bus.mem_addr, bus.tx_data, bus.tx_valid, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) late++;
        end
        checks++;
        if (late !== 0) begin errors++; $display("FAIL rstmid residue: %0d active cycles after reset, required 0", late); end
        run_op(OP_SHOWMOVE, $urandom_range(0, DEPTH - 1), 0, 80, 0, 1'b0);
        checks += 2;
        if (got_b_s != exp_b_s) begin errors++; $display("FAIL rstmid restart bytes: got [%s] required [%s]", got_b_s, exp_b_s); end
        if (done_cnt !== 1) begin errors++; $display("FAIL rstmid restart done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] act [5];
        logic [3:0] op;
        int         base, len, pct;
        act[0] = OP_SHOWMOVE; act[1] = OP_SHOWADD; act[2] = OP_SHOWSUB; act[3] = OP_SHOWMUL; act[4] = OP_SHOW;
        for (int n = 0; n < 10; n++) begin
            fill_mem();
            op   = ($urandom_range(0, 1) == 1) ? act[$urandom_range(0, 4)] : 4'($urandom_range(0, 15));
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, DEPTH);
            pct  = $urandom_range(30, 100);
            run_op(op, base, len, pct, 0, 1'($urandom_range(0, 1)));
            checks += 4;
            if (got_b_s != exp_b_s) begin
                errors++; $display("FAIL rand%0d op=%b bytes: got [%s] required [%s]", n, op, got_b_s, exp_b_s);
            end
            if (got_a_s != exp_a_s) begin
                errors++; $display("FAIL rand%0d op=%b addrs: got [%s] required [%s]", n, op, got_a_s, exp_a_s);
            end
            if (done_cnt !== int'(exp_active)) begin
                errors++; $display("FAIL rand%0d op=%b done pulses: got %0d required %0d", n, op, done_cnt, int'(exp_active));
            end
            if (hold_bad + gap_bad + busy_bad !== 0) begin
                errors++; $display("FAIL rand%0d protocol: hold=%0d gap=%0d busy=%0d, required 0", n, hold_bad, gap_bad, busy_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_showadd();
        test_showmul();
        test_show_wrap();
        test_stall();
        test_ignored_and_empty();
        test_full_dump();
        test_reset_midway();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
